// File: rtl/irq_vector_encoder_pkg.sv
// Shared constants, FSM state encoding and a one-hot helper for the IRQ vector encoder.
package irq_vector_encoder_pkg;

    localparam int unsigned N_SRC = 16;
    localparam int unsigned IDX_W = $clog2(N_SRC);

    typedef enum logic {
        StIdle    = 1'b0,
        StPresent = 1'b1
    } state_e;

    function automatic logic [N_SRC-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_SRC-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/irq_vector_encoder_if.sv
// Vector handshake between the IRQ encoder (master) and the exception/control unit (slave).
interface irq_vector_encoder_if;
    import irq_vector_encoder_pkg::*;

    logic             vec_valid;
    logic [IDX_W-1:0] vec_idx;
    logic             vec_ack;

    modport master (
        output vec_valid,
        output vec_idx,
        input  vec_ack
    );

    modport slave (
        input  vec_valid,
        input  vec_idx,
        output vec_ack
    );

endinterface

// File: rtl/irq_vector_encoder_prio_enc16.sv
// Combinational 16-to-4 priority encoder; the lowest set bit wins.
module irq_vector_encoder_prio_enc16
    import irq_vector_encoder_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan high to low so the last hit, and therefore the result, is the lowest index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_vector_encoder.sv
// Edge-captured, masked, lowest-index-first interrupt vector encoder with a valid/ack output.
module irq_vector_encoder
    import irq_vector_encoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     irq_in,
    input  logic [N_SRC-1:0]     irq_mask,
    output logic [N_SRC-1:0]     pending,
    output logic                 irq_any,
    irq_vector_encoder_if.master vec
);

    state_e           state_q, state_d;
    logic [N_SRC-1:0] irq_prev_q, irq_prev_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] vec_idx_q, vec_idx_d;

    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_found;

    assign eligible = pending_q & ~irq_mask;
    assign rise     = irq_in & ~irq_prev_q;

    irq_vector_encoder_prio_enc16 u_prio_enc (
        .req   (eligible),
        .idx   (enc_idx),
        .found (enc_found)
    );

    always_comb begin
        state_d   = state_q;
        vec_idx_d = vec_idx_q;
        clr       = '0;
        unique case (state_q)
            StIdle: begin
                if (enc_found) begin
                    state_d   = StPresent;
                    vec_idx_d = enc_idx;
                end
            end
            StPresent: begin
                // Index stays frozen until ack, regardless of new requests or mask changes.
                if (vec.vec_ack) begin
                    state_d = StIdle;
                    clr     = idx_to_onehot(vec_idx_q);
                end
            end
        endcase
    end

    // A fresh rise on the acknowledged bit survives the clear.
    always_comb begin
        irq_prev_d = irq_in;
        pending_d  = (pending_q & ~clr) | rise;
    end

    // irq_prev resets high so lines already asserted at reset release are not captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            irq_prev_q <= '1;
            pending_q  <= '0;
            vec_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            vec_idx_q  <= vec_idx_d;
        end
    end

    assign pending       = pending_q;
    assign irq_any       = |eligible;
    assign vec.vec_valid = (state_q == StPresent);
    assign vec.vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_irq_vector_encoder.sv
// Table-driven plus hand-sequenced bench for irq_vector_encoder with an expected-vector queue.
module tb_irq_vector_encoder;
    import irq_vector_encoder_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_SRC-1:0] irq_in;
    logic [N_SRC-1:0] irq_mask;
    logic [N_SRC-1:0] pending;
    logic             irq_any;

    irq_vector_encoder_if vif ();

    irq_vector_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .irq_mask (irq_mask),
        .pending  (pending),
        .irq_any  (irq_any),
        .vec      (vif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_SRC-1:0] pat;
        logic [N_SRC-1:0] mask;
        logic             any;
        logic [IDX_W-1:0] idx;
    } vec_t;

    vec_t             tbl [7];
    logic [IDX_W-1:0] exp_q [$];
    int               n_cmp  = 0;
    int               n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait for a presented vector, compare it with the scoreboard head, then acknowledge it.
    task automatic ack_vec(output int waited);
        logic [IDX_W-1:0] exp_idx;
        waited = 0;
        while (!vif.vec_valid && waited < 10) begin
            tick();
            waited++;
        end
        check("vec_valid_wait", 32'(vif.vec_valid), 32'd1);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_underflow: got vector 0x%0h, want none", vif.vec_idx);
        end else begin
            exp_idx = exp_q.pop_front();
            check("vec_idx", 32'(vif.vec_idx), 32'(exp_idx));
        end
        vif.vec_ack = 1'b1;
        tick();
        vif.vec_ack = 1'b0;
        check("gap_valid", 32'(vif.vec_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;

        tbl[0] = '{pat: 16'h0020, mask: 16'h0000, any: 1'b1, idx: 4'd5};
        tbl[1] = '{pat: 16'h0208, mask: 16'h0000, any: 1'b1, idx: 4'd3};
        tbl[2] = '{pat: 16'h0010, mask: 16'h0010, any: 1'b0, idx: 4'd0};
        tbl[3] = '{pat: 16'h8001, mask: 16'h0001, any: 1'b1, idx: 4'd15};
        tbl[4] = '{pat: 16'hFFFF, mask: 16'h0000, any: 1'b1, idx: 4'd0};
        tbl[5] = '{pat: 16'h0000, mask: 16'h0000, any: 1'b0, idx: 4'd0};
        tbl[6] = '{pat: 16'h8000, mask: 16'h7FFF, any: 1'b1, idx: 4'd15};

        // Reset with bit 0 held high: it must never be captured.
        rst         = 1'b1;
        irq_in      = 16'h0001;
        irq_mask    = '0;
        vif.vec_ack = 1'b0;
        tick();
        tick();
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_valid", 32'(vif.vec_valid), 32'd0);
        check("rst_idx", 32'(vif.vec_idx), 32'd0);
        check("rst_irq_any", 32'(irq_any), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("held_pending", 32'(pending), 32'd0);
            check("held_valid", 32'(vif.vec_valid), 32'd0);
        end
        irq_in = '0;
        tick();

        foreach (tbl[t]) begin
            irq_mask = tbl[t].mask;
            irq_in   = tbl[t].pat;
            tick();
            irq_in = '0;
            check("cap_pending", 32'(pending), 32'(tbl[t].pat));
            check("cap_irq_any", 32'(irq_any), 32'(tbl[t].any));
            check("cap_valid", 32'(vif.vec_valid), 32'd0);
            tick();
            check("pres_valid", 32'(vif.vec_valid), 32'(tbl[t].any));
            if (tbl[t].any) begin
                check("pres_idx", 32'(vif.vec_idx), 32'(tbl[t].idx));
                exp_q.push_back(tbl[t].idx);
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (tbl[t].pat[i] && !(tbl[t].any && tbl[t].idx == IDX_W'(i)))
                    exp_q.push_back(IDX_W'(i));
            end
            irq_mask = '0;
            n = exp_q.size();
            for (int k = 0; k < n; k++) begin
                ack_vec(w);
                if (k > 0) check("b2b_gap", 32'(w), 32'd1);
            end
            check("drain_pending", 32'(pending), 32'd0);
        end

        // Higher-priority rise while presenting 9 must not disturb the frozen index.
        irq_in = 16'h0200;
        tick();
        irq_in = '0;
        tick();
        irq_in = 16'h0004;
        tick();
        irq_in = '0;
        tick();
        tick();
        check("frozen_valid", 32'(vif.vec_valid), 32'd1);
        check("frozen_idx", 32'(vif.vec_idx), 32'd9);
        check("frozen_pending", 32'(pending), 32'h0204);
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd2);
        ack_vec(w);
        ack_vec(w);
        check("frozen_b2b", 32'(w), 32'd1);
        check("frozen_drain", 32'(pending), 32'd0);

        // Ack while idle has no effect.
        irq_mask = 16'h0800;
        irq_in   = 16'h0800;
        tick();
        irq_in      = '0;
        vif.vec_ack = 1'b1;
        repeat (3) tick();
        vif.vec_ack = 1'b0;
        check("idle_ack_pending", 32'(pending), 32'h0800);
        check("idle_ack_valid", 32'(vif.vec_valid), 32'd0);
        irq_mask = '0;
        exp_q.push_back(4'd11);
        ack_vec(w);
        check("unmask_latency", 32'(w), 32'd1);
        check("idle_ack_drain", 32'(pending), 32'd0);

        // Masking the presented source does not withdraw it.
        irq_in = 16'h0040;
        tick();
        irq_in = '0;
        tick();
        irq_mask = 16'h0040;
        tick();
        check("mask_pres_valid", 32'(vif.vec_valid), 32'd1);
        check("mask_pres_idx", 32'(vif.vec_idx), 32'd6);
        check("mask_pres_any", 32'(irq_any), 32'd0);
        exp_q.push_back(4'd6);
        ack_vec(w);
        check("mask_pres_clr", 32'(pending), 32'd0);
        irq_mask = '0;

        // Ack of 7 coincides with a fresh rise on 7: set wins, 7 is re-presented.
        irq_in = 16'h0080;
        tick();
        irq_in = '0;
        tick();
        check("coll_idx", 32'(vif.vec_idx), 32'd7);
        vif.vec_ack = 1'b1;
        irq_in      = 16'h0080;
        tick();
        vif.vec_ack = 1'b0;
        irq_in      = '0;
        check("coll_pending", 32'(pending), 32'h0080);
        check("coll_gap", 32'(vif.vec_valid), 32'd0);
        tick();
        check("coll_repres_valid", 32'(vif.vec_valid), 32'd1);
        exp_q.push_back(4'd7);
        ack_vec(w);
        check("coll_drain", 32'(pending), 32'd0);

        // Async reset mid-present; held line is not recaptured until it toggles.
        irq_in = 16'h1000;
        tick();
        tick();
        check("rstp_pre_valid", 32'(vif.vec_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rstp_valid", 32'(vif.vec_valid), 32'd0);
        check("rstp_pending", 32'(pending), 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rstp_hold_pending", 32'(pending), 32'd0);
        check("rstp_hold_valid", 32'(vif.vec_valid), 32'd0);
        irq_in = '0;
        tick();
        irq_in = 16'h1000;
        tick();
        irq_in = '0;
        check("rstp_recap", 32'(pending), 32'h1000);
        exp_q.push_back(4'd12);
        ack_vec(w);
        check("rstp_drain", 32'(pending), 32'd0);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
